glitch_monitor: RTL and testbench

Measurement receiver for the glitch path: watches a trigger line and a glitch line and reports, per trigger, the delay from trigger to glitch onset and the glitch width, both in clock cycles. It sits on the receive side of a loopback, with the glitch generator's trigger and glitch outputs wired in. It runs in the 204 MHz PLL domain and gives on-chip self-test and calibration of delay/width settings. Each result is handed to a consumer (UART/logger) over a valid/ready handshake.

---
 rtl/glitch_pkg.sv | 16 +
 rtl/sync_2ff.sv | 22 ++
 rtl/glitch_monitor.sv | 124 ++++++++++++
 tb/tb_glitch_monitor.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/glitch_pkg.sv
// glitch_pkg: types and constants shared by the glitch generator and glitch_monitor.
package glitch_pkg;

    // Measurement FSM encoding (3 bits)
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_PULSE    = 3'd2,
        ST_REPORT   = 3'd3,
        ST_WAIT_LOW = 3'd4
    } state_e;

    // Default glitch-width field width, common to generator and monitor
    localparam int DEFAULT_WIDTH_W = 16;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer, both flops cleared by rst_n.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of an asynchronous level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/glitch_monitor.sv
// glitch_monitor: per trigger, measures cycles from arm to glitch onset and the
// glitch width, then offers the result over valid/ready.
// Build option: GLITCH_MONITOR_SYNC_EN puts trigger and glitch through 2-flop
// synchronizers (equal latency on both, so measured values do not change).
module glitch_monitor
    import glitch_pkg::*;
#(
    parameter int          DELAY_W = 32,
    parameter int          WIDTH_W = DEFAULT_WIDTH_W,
    parameter logic [31:0] TIMEOUT = 32'd0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               trigger,
    input  logic               glitch,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [DELAY_W-1:0] delay_count,
    output logic [WIDTH_W-1:0] width_count,
    output logic               timed_out,
    output logic               overflow,
    output logic               busy
);

    localparam logic [DELAY_W-1:0] DLY_MAX = '1;
    localparam logic [DELAY_W-1:0] DLY_ONE = DELAY_W'(1);
    localparam logic [DELAY_W-1:0] DLY_TMO = DELAY_W'(TIMEOUT);
    localparam logic [WIDTH_W-1:0] WID_MAX = '1;
    localparam logic [WIDTH_W-1:0] WID_ONE = WIDTH_W'(1);

    logic               trig_s, glit_s;
    state_e             state, state_nxt;
    logic [DELAY_W-1:0] dly_cnt, dly_inc;
    logic [WIDTH_W-1:0] wid_cnt, wid_inc;
    logic               timeout_hit;

`ifdef GLITCH_MONITOR_SYNC_EN
    sync_2ff u_sync_trig (.clk(clk), .rst_n(rst_n), .d(trigger), .q(trig_s));
    sync_2ff u_sync_glit (.clk(clk), .rst_n(rst_n), .d(glitch),  .q(glit_s));
`else
    assign trig_s = trigger;
    assign glit_s = glitch;
`endif

    assign dly_inc     = dly_cnt + DLY_ONE;
    assign wid_inc     = wid_cnt + WID_ONE;
    assign timeout_hit = (TIMEOUT != 32'd0) && (dly_cnt == DLY_TMO);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: abort beats glitch beats timeout while armed
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (trig_s) state_nxt = ST_ARMED;
            ST_ARMED: begin
                if (!trig_s)         state_nxt = ST_IDLE;
                else if (glit_s)     state_nxt = ST_PULSE;
                else if (timeout_hit) state_nxt = ST_REPORT;
            end
            ST_PULSE:    if (!glit_s) state_nxt = ST_REPORT;
            ST_REPORT:   if (result_ready) state_nxt = ST_WAIT_LOW;
            ST_WAIT_LOW: if (!trig_s) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Saturating counters and registered result/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_cnt      <= '0;
            wid_cnt      <= '0;
            delay_count  <= '0;
            width_count  <= '0;
            timed_out    <= 1'b0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            busy         <= (state_nxt != ST_IDLE);
            result_valid <= (state_nxt == ST_REPORT);
            case (state)
                ST_ARMED: begin
                    if (!trig_s) begin
                        dly_cnt <= '0;
                    end else if (glit_s) begin
                        delay_count <= dly_cnt;
                        wid_cnt     <= WID_ONE;
                        if (WID_ONE == WID_MAX) overflow <= 1'b1;
                    end else if (timeout_hit) begin
                        timed_out   <= 1'b1;
                        delay_count <= DLY_TMO;
                        width_count <= '0;
                    end else if (dly_cnt != DLY_MAX) begin
                        dly_cnt <= dly_inc;
                        if (dly_inc == DLY_MAX) overflow <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (!glit_s) begin
                        width_count <= wid_cnt;
                    end else if (wid_cnt != WID_MAX) begin
                        wid_cnt <= wid_inc;
                        if (wid_inc == WID_MAX) overflow <= 1'b1;
                    end
                end
                default: begin
                    dly_cnt <= '0;
                    wid_cnt <= '0;
                    // Fresh measurement: clear sticky status on ARMED entry
                    if (state == ST_IDLE && trig_s) begin
                        timed_out <= 1'b0;
                        overflow  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glitch_monitor.sv
// tb_glitch_monitor: directed + randomized measurements against a per-transaction
// arithmetic model (DELAY_W=16, WIDTH_W=4, TIMEOUT=20).
module tb_glitch_monitor;

    localparam int DW  = 16;
    localparam int WW  = 4;
    localparam int TMO = 20;

    typedef struct {
        logic [DW-1:0] d;
        logic [WW-1:0] w;
        logic          to;
        logic          ov;
    } res_t;

    logic          pll_clk_out = 1'b0;
    logic          rst_n = 1'b0;
    logic          trigger = 1'b0;
    logic          glitch = 1'b0;
    logic          result_ready = 1'b1;
    logic          result_valid;
    logic [DW-1:0] delay_count;
    logic [WW-1:0] width_count;
    logic          timed_out, overflow, busy;

    int   n_vec = 0;
    int   n_err = 0;
    int   valid_cycles = 0;
    res_t hs_q[$];

    glitch_monitor #(.DELAY_W(DW), .WIDTH_W(WW), .TIMEOUT(32'd20)) dut (
        .clk(pll_clk_out), .rst_n(rst_n), .trigger(trigger), .glitch(glitch),
        .result_valid(result_valid), .result_ready(result_ready),
        .delay_count(delay_count), .width_count(width_count),
        .timed_out(timed_out), .overflow(overflow), .busy(busy)
    );

    always #5 pll_clk_out = ~pll_clk_out;

    // Record every valid cycle and every accepted result
    always @(negedge pll_clk_out) begin
        if (rst_n && result_valid) begin
            valid_cycles++;
            if (result_ready) hs_q.push_back('{delay_count, width_count, timed_out, overflow});
        end
    end

    // Expected result for glitch starting d cycles after arming, high for w cycles
    function automatic res_t model(int d, int w);
        res_t r;
        int   wmax = (1 << WW) - 1;
        if (d > TMO) begin
            r = '{DW'(TMO), '0, 1'b1, 1'b0};
        end else begin
            r.d  = DW'(d);
            r.w  = WW'((w > wmax) ? wmax : w);
            r.to = 1'b0;
            r.ov = (w >= wmax);
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge pll_clk_out);
        #1;
    endtask

    task automatic run_meas(int d, int w);
        int   base_hs = hs_q.size();
        int   base_vc = valid_cycles;
        res_t e = model(d, w);
        trigger = 1'b1;
        glitch  = 1'b0;
        tick();
        repeat (d) tick();
        glitch = 1'b1;
        repeat (w) tick();
        glitch = 1'b0;
        for (int i = 0; i < 40 && hs_q.size() == base_hs; i++) tick();
        repeat (2) tick();
        chk("no_rearm_busy", {31'd0, busy}, 32'd1);
        trigger = 1'b0;
        repeat (2) tick();
        chk("busy_after_drop", {31'd0, busy}, 32'd0);
        chk("handshakes", hs_q.size() - base_hs, 32'd1);
        chk("valid_cycles", valid_cycles - base_vc, 32'd1);
        if (hs_q.size() > base_hs) begin
            chk("delay_count", {16'd0, hs_q[base_hs].d}, {16'd0, e.d});
            chk("width_count", {28'd0, hs_q[base_hs].w}, {28'd0, e.w});
            chk("timed_out",   {31'd0, hs_q[base_hs].to}, {31'd0, e.to});
            chk("overflow",    {31'd0, hs_q[base_hs].ov}, {31'd0, e.ov});
        end
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_valid"}, {31'd0, result_valid}, 32'd0);
        chk({tag, "_delay"}, {16'd0, delay_count}, 32'd0);
        chk({tag, "_width"}, {28'd0, width_count}, 32'd0);
        chk({tag, "_to"},    {31'd0, timed_out}, 32'd0);
        chk({tag, "_ov"},    {31'd0, overflow}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [DW-1:0] sd;
        logic [WW-1:0] sw;
        int            base_vc;

        // Reset state
        #12;
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Basic measurement, delay 10 / width 5
        run_meas(10, 5);

        // Reset asserted mid-PULSE
        trigger = 1'b1;
        tick();
        repeat (3) tick();
        glitch = 1'b1;
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("rst_pulse");
        trigger = 1'b0;
        glitch  = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run_meas(7, 2);

        // Boundaries: immediate glitch, glitch exactly at timeout, timeout, width saturation
        run_meas(0, 1);
        run_meas(20, 3);
        run_meas(21, 2);
        run_meas(30, 1);
        run_meas(2, 40);
        run_meas(1, 14);

        // Trigger dropped while armed: no result, busy falls one cycle later
        base_vc = valid_cycles;
        trigger = 1'b1;
        tick();
        repeat (3) tick();
        chk("abort_busy_hi", {31'd0, busy}, 32'd1);
        trigger = 1'b0;
        tick();
        chk("abort_busy_lo", {31'd0, busy}, 32'd0);
        repeat (5) tick();
        chk("abort_no_valid", valid_cycles - base_vc, 32'd0);

        // Consumer stalls 7 cycles; outputs hold while glitch toggles
        result_ready = 1'b0;
        trigger = 1'b1;
        tick();
        repeat (3) tick();
        glitch = 1'b1;
        repeat (4) tick();
        glitch = 1'b0;
        for (int i = 0; i < 10 && !result_valid; i++) tick();
        chk("stall_delay", {16'd0, delay_count}, 32'd3);
        chk("stall_width", {28'd0, width_count}, 32'd4);
        sd = delay_count;
        sw = width_count;
        for (int i = 0; i < 7; i++) begin
            glitch = $urandom_range(0, 1) != 0;
            tick();
            chk("stall_valid", {31'd0, result_valid}, 32'd1);
            chk("stall_hold_d", {16'd0, delay_count}, {16'd0, sd});
            chk("stall_hold_w", {28'd0, width_count}, {28'd0, sw});
        end
        result_ready = 1'b1;
        tick();
        chk("stall_accept", {31'd0, result_valid}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            glitch = ~glitch;
            tick();
            chk("wait_low_busy", {31'd0, busy}, 32'd1);
            chk("wait_low_valid", {31'd0, result_valid}, 32'd0);
        end
        glitch  = 1'b0;
        trigger = 1'b0;
        tick();
        chk("wait_low_exit", {31'd0, busy}, 32'd0);

        // Randomized measurements
        for (int i = 0; i < 16; i++) begin
            run_meas(int'($urandom_range(0, 25)), int'($urandom_range(1, 20)));
            repeat (int'($urandom_range(0, 3))) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule
